// File: rtl/clk_gate_pkg.sv
// rtl/clk_gate_pkg.sv - shared state encoding and integration defaults for the clock-gate controller
package clk_gate_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_IDLE_CYCLES = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_gate_timer.sv
// rtl/clk_gate_ctrl_gate_timer.sv - loadable down-counter shared by the wake and hold phases
module gate_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - registered clock-gate enable controller with wake grant and idle hold-off
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             busy,
  input  logic             force_on,
  output logic             clk_en,
  output logic             gnt,
  output logic [CNT_W-1:0] gate_cnt
);

  localparam int MAXC = max_int(WAKE_CYCLES, IDLE_CYCLES);
  localparam int TW   = (MAXC < 2) ? 1 : $clog2(MAXC);
  localparam logic [TW-1:0] WAKE_LOAD = TW'(WAKE_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LOAD = TW'(IDLE_CYCLES - 1);

  state_t        state, state_next;
  logic          t_load, t_dec, t_zero, cnt_inc;
  logic [TW-1:0] t_value;
  logic          idle, wake;

  assign idle = !req && !busy && !force_on;
  assign wake = req || force_on;

  gate_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (t_load),
    .value (t_value),
    .dec   (t_dec),
    .zero  (t_zero)
  );

  always_comb begin
    state_next = state;
    t_load     = 1'b0;
    t_value    = '0;
    t_dec      = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      ST_OFF: if (wake) begin
        state_next = ST_WAKE;
        t_load     = 1'b1;
        t_value    = WAKE_LOAD;
      end
      ST_WAKE: if (t_zero) state_next = ST_ON;
               else        t_dec      = 1'b1;
      ST_ON: if (idle) begin
        state_next = ST_HOLD;
        t_load     = 1'b1;
        t_value    = IDLE_LOAD;
      end
      // Any sign of activity wins over an expiring hold, including on the zero cycle.
      ST_HOLD: if (!idle) begin
        state_next = ST_ON;
      end else if (t_zero) begin
        state_next = ST_OFF;
        cnt_inc    = 1'b1;
      end else begin
        t_dec = 1'b1;
      end
      default: state_next = ST_OFF;
    endcase
  end

  // Outputs are flopped from next-state so the gate latch never sees input glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_OFF;
      clk_en   <= 1'b0;
      gnt      <= 1'b0;
      gate_cnt <= '0;
    end else begin
      state  <= state_next;
      clk_en <= (state_next != ST_OFF);
      gnt    <= (state_next == ST_ON) || (state_next == ST_HOLD);
      if (cnt_inc && (gate_cnt != {CNT_W{1'b1}})) begin
        gate_cnt <= gate_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Clock-gating enable controller: the driver side of the system's latch-based clock-gate cell. It turns requests from a gated-domain client (e.g. ALU) into a registered, glitch-safe `CLK_EN`. It signals the client with `GNT` once the gated clock is stable, and holds the clock on for a programmable idle period before gating it off. It sits in the always-on domain next to the system controller, with `CLK_EN` wired directly to the gate cell's enable.

## Interface
- `WAKE_CYCLES`, default 2: ungated-clock cycles from `CLK_EN` rising to `GNT` rising. Must be >= 1.
- `IDLE_CYCLES`, default 4: cycles of continuous idle in ON/HOLD before `CLK_EN` falls. Must be >= 1.
- `CNT_W`, default 8: width of the gate-off event counter.
- `CLK  in  1`: always-on clock; the same clock that feeds the gate cell.
- `RST  in  1`: reset, asynchronous, active-high.
- `REQ  in  1`: client needs the gated clock. Level, synchronous to `CLK`.
- `BUSY  in  1`: gated domain still finishing work. Keeps the clock on and does not wake it.
- `FORCE_ON  in  1`: debug/scan override. Acts as a permanent `REQ`.
- `CLK_EN  out  1`: registered enable to the gate cell.
- `GNT  out  1`: registered; the gated clock is running and stable.
- `GATE_CNT  out  CNT_W`: number of ON-to-OFF gate events, saturating.

## Operation
- Idle condition: `IDLE = !REQ && !BUSY && !FORCE_ON`. Wake condition: `WAKE = REQ || FORCE_ON`.
- FSM states: OFF, WAKE, ON, HOLD.
- **OFF**
  - Outputs: `CLK_EN=0`, `GNT=0`.
  - `WAKE` goes to WAKE and loads the wake counter with `WAKE_CYCLES-1`.
  - `BUSY` alone does nothing.
- **WAKE**
  - Outputs: `CLK_EN=1`, `GNT=0`.
  - The counter decrements each cycle.
  - When the counter is 0, go to ON. This happens regardless of `REQ` (the wake is never aborted).
- **ON**
  - Outputs: `CLK_EN=1`, `GNT=1`.
  - `IDLE` goes to HOLD and loads the idle counter with `IDLE_CYCLES-1`.
- **HOLD**
  - Outputs: `CLK_EN=1`, `GNT=1`.
  - `!IDLE` returns to ON; the counter is discarded.
  - Otherwise the counter decrements.
  - When the counter is 0 and still `IDLE`, go to OFF and increment `GATE_CNT`. The counter saturates at all-ones.
- Simultaneous events: `REQ` rising in the same cycle the HOLD counter reaches 0 means stay on (go to ON). Wake takes priority over gate-off.
- `CLK_EN` and `GNT` are driven only from flops, with no combinational path from inputs. This keeps the latch in the gate cell glitch-free.

## Timing
- Reset values: state OFF, `CLK_EN=0`, `GNT=0`, `GATE_CNT=0`, both counters 0.
- Reset assertion clears all of these immediately and asynchronously, including mid-WAKE and mid-HOLD.
- Wake latency:
  - `REQ` sampled high at edge n in OFF gives `CLK_EN=1` after edge n.
  - `GNT=1` follows after edge n+`WAKE_CYCLES`.
- The client must not use the gated clock before `GNT=1`. `GNT` falls in the same cycle as `CLK_EN`.
- Gate-off latency: first idle sample at edge m in ON gives HOLD after edge m. `CLK_EN=0` and `GNT=0` follow after edge m+`IDLE_CYCLES`.
- Re-request after gate-off: a full wake sequence is required; there is no shortcut from OFF to ON.
- `FORCE_ON` held high: the controller never leaves ON (after the initial wake), and `GATE_CNT` is frozen.

## Structure
- Shared package `clk_gate_pkg` contains:
  - the state enum (OFF, WAKE, ON, HOLD), 2 bits;
  - default `WAKE_CYCLES`/`IDLE_CYCLES` constants for system integration.
- One natural sub-module, `gate_timer`: a loadable down-counter with `load`, `value`, `dec` and a `zero` flag. It is instantiated once and shared by WAKE and HOLD, since they never overlap.
- The system top instantiates `clk_gate_ctrl` next to the existing clock-gate cell. The gate cell itself is not inside this block.

## Test plan
The bench uses `WAKE_CYCLES=2`, `IDLE_CYCLES=4`, `CNT_W=8`.
1. Basic wake: pulse `REQ` high at edge 10 and hold it -> `CLK_EN=1` after edge 10, `GNT=1` after edge 12, and both stay high.
2. Idle gate-off: drop `REQ` at edge 20 with `BUSY=0` -> `CLK_EN`/`GNT` fall after edge 24, `GATE_CNT=1`.
3. HOLD rescue: drop `REQ` at edge 20 and re-raise it at edge 23 -> `CLK_EN` never falls, state returns to ON after edge 23, `GATE_CNT` unchanged. Boundary case: re-raise at edge 24 -> still no gate-off.
4. `BUSY` extension and `FORCE_ON`:
   - `BUSY=1` from edge 20 to edge 30 with `REQ=0` -> `CLK_EN` falls after edge 34.
   - `FORCE_ON=1` from OFF -> wake completes, and the controller stays in ON for 1000 cycles with `GATE_CNT` constant.
5. Reset mid-operation: assert `RST` asynchronously mid-WAKE and again mid-HOLD -> `CLK_EN=0`, `GNT=0`, `GATE_CNT=0` immediately. After release with `REQ=1`, a fresh 2-cycle wake follows.
6. Saturation: run 260 wake/gate-off cycles -> `GATE_CNT` stops at 255. `WAKE` asserted at the HOLD-zero edge -> remains ON.
